// File: rtl/dizi_hizalama_kontrol_if.sv
// Handshake and result bus of the codon alignment checker.
// The width of toplam follows N_KODON so that 3*N_KODON fits exactly.
interface dizi_hizalama_kontrol_if #(
  parameter int N_KODON = 8
);
  localparam int W = $clog2(3*N_KODON+1);

  logic         basla;
  logic         iptal;
  logic         giris_gecerli;
  logic [5:0]   kodon1;
  logic [5:0]   kodon2;
  logic         giris_hazir;
  logic [1:0]   skor;
  logic [W-1:0] toplam;
  logic [7:0]   tam_sayi;
  logic         mesgul;
  logic         bitti;
  logic         gecti;

  modport master (
    output basla, iptal, giris_gecerli, kodon1, kodon2,
    input  giris_hazir, skor, toplam, tam_sayi, mesgul, bitti, gecti
  );

  modport slave (
    input  basla, iptal, giris_gecerli, kodon1, kodon2,
    output giris_hazir, skor, toplam, tam_sayi, mesgul, bitti, gecti
  );
endinterface

// File: rtl/dizi_hizalama_kontrol.sv
// Codon-pair alignment scorer: scores N_KODON pairs per job, accumulates a
// total and a perfect-match count, then pulses bitti with a pass verdict.
module dizi_hizalama_kontrol #(
  parameter int N_KODON = 8,
  parameter int ESIK    = 12
) (
  input logic                     clk,
  input logic                     rst,
  dizi_hizalama_kontrol_if.slave  bus
);
  localparam int          W      = $clog2(3*N_KODON+1);
  localparam logic [7:0]  N_U    = 8'(N_KODON);
  localparam logic [31:0] ESIK_U = ESIK;

  typedef enum logic [1:0] {BOSTA, CALIS, BOSALT, BITTI} durum_t;

  durum_t       durum, durum_d;
  logic [7:0]   sayac;
  logic         bos_sayac;
  logic         skor_vld;
  logic [1:0]   skor;
  logic [W-1:0] toplam;
  logic [7:0]   tam_sayi;
  logic         gecti;
  logic         xfer;
  logic         iptal_et;
  logic [2:0]   esit;
  logic [1:0]   puan;

  assign bus.giris_hazir = (durum == CALIS) && (sayac < N_U);
  assign bus.skor        = skor;
  assign bus.toplam      = toplam;
  assign bus.tam_sayi    = tam_sayi;
  assign bus.gecti       = gecti;
  assign bus.mesgul      = (durum != BOSTA);
  assign bus.bitti       = (durum == BITTI);

  assign xfer     = bus.giris_gecerli && bus.giris_hazir;
  assign iptal_et = bus.iptal && (durum == CALIS || durum == BOSALT);

  // One bit per nucleotide position that matches.
  assign esit[2] = (bus.kodon1[5:4] == bus.kodon2[5:4]);
  assign esit[1] = (bus.kodon1[3:2] == bus.kodon2[3:2]);
  assign esit[0] = (bus.kodon1[1:0] == bus.kodon2[1:0]);
  assign puan    = {1'b0, esit[2]} + {1'b0, esit[1]} + {1'b0, esit[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) durum <= BOSTA;
    else     durum <= durum_d;
  end

  always_comb begin
    durum_d = durum;
    case (durum)
      BOSTA:  if (bus.basla && !bus.iptal) durum_d = CALIS;
      CALIS:  if (bus.iptal) durum_d = BOSTA;
              else if (xfer && sayac == N_U - 8'd1) durum_d = BOSALT;
      BOSALT: if (bus.iptal) durum_d = BOSTA;
              else if (bos_sayac) durum_d = BITTI;
      BITTI:  durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sayac     <= '0;
      bos_sayac <= 1'b0;
      skor_vld  <= 1'b0;
      skor      <= '0;
      toplam    <= '0;
      tam_sayi  <= '0;
      gecti     <= 1'b0;
    end else if (durum == BOSTA) begin
      if (durum_d == CALIS) begin
        sayac     <= '0;
        bos_sayac <= 1'b0;
        skor_vld  <= 1'b0;
        skor      <= '0;
        toplam    <= '0;
        tam_sayi  <= '0;
        gecti     <= 1'b0;
      end
    end else if (iptal_et) begin
      // Drop any score still in flight; partial totals stay visible.
      skor_vld  <= 1'b0;
      bos_sayac <= 1'b0;
      gecti     <= 1'b0;
    end else begin
      skor_vld <= xfer;
      if (xfer) begin
        skor  <= puan;
        sayac <= sayac + 8'd1;
      end
      if (skor_vld) begin
        toplam <= toplam + W'(skor);
        if (skor == 2'd3) tam_sayi <= tam_sayi + 8'd1;
      end
      bos_sayac <= (durum == BOSALT) ? ~bos_sayac : 1'b0;
      // Last score has landed in toplam by the second drain cycle.
      if (durum == BOSALT && bos_sayac) gecti <= (32'(toplam) >= ESIK_U);
    end
  end
endmodule

// File: tb/tb_dizi_hizalama_kontrol.sv
// Bench for dizi_hizalama_kontrol: per-pair scores via a scoreboard queue,
// job results against fixed expectations.
module tb_dizi_hizalama_kontrol;
  localparam int N_KODON = 8;
  localparam int ESIK    = 12;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   sb[$];
  bit   pend = 1'b0;

  always #5 clk = ~clk;

  dizi_hizalama_kontrol_if #(.N_KODON(N_KODON)) bus ();

  dizi_hizalama_kontrol #(.N_KODON(N_KODON), .ESIK(ESIK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic kontrol(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model(input logic [5:0] a, input logic [5:0] b);
    int s = 0;
    for (int i = 0; i < 3; i++)
      if (a[2*i +: 2] == b[2*i +: 2]) s++;
    return s;
  endfunction

  // A transfer seen before an edge must show up on skor after that edge.
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
      sb.delete();
    end else begin
      if (pend) begin
        if (sb.size() == 0) kontrol("sb_empty", 1, 0);
        else kontrol("skor", int'(bus.skor), sb.pop_front());
      end
      pend = bus.giris_gecerli && bus.giris_hazir && !bus.iptal;
      if (pend) sb.push_back(model(bus.kodon1, bus.kodon2));
    end
  end

  task automatic start_job();
    @(posedge clk); #1 bus.basla = 1'b1;
    @(posedge clk); #1 bus.basla = 1'b0;
  endtask

  task automatic send(input logic [5:0] a, input logic [5:0] b, input int gap);
    bus.kodon1 = a;
    bus.kodon2 = b;
    bus.giris_gecerli = 1'b1;
    @(posedge clk); #1 bus.giris_gecerli = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Called right after the last transfer edge; bitti expected on the 3rd cycle.
  task automatic finish_job(input string tag, input int e_top, input int e_tam, input int e_gec);
    @(negedge clk);
    kontrol({tag, "_hazir_drop"}, int'(bus.giris_hazir), 0);
    kontrol({tag, "_bitti_c1"}, int'(bus.bitti), 0);
    @(negedge clk);
    kontrol({tag, "_bitti_c2"}, int'(bus.bitti), 0);
    @(negedge clk);
    kontrol({tag, "_bitti_c3"}, int'(bus.bitti), 1);
    kontrol({tag, "_toplam"}, int'(bus.toplam), e_top);
    kontrol({tag, "_tam_sayi"}, int'(bus.tam_sayi), e_tam);
    kontrol({tag, "_gecti"}, int'(bus.gecti), e_gec);
    @(negedge clk);
    kontrol({tag, "_bitti_c4"}, int'(bus.bitti), 0);
    kontrol({tag, "_mesgul_end"}, int'(bus.mesgul), 0);
    kontrol({tag, "_gecti_hold"}, int'(bus.gecti), e_gec);
    kontrol({tag, "_toplam_hold"}, int'(bus.toplam), e_top);
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    kontrol({tag, "_hazir"}, int'(bus.giris_hazir), 0);
    kontrol({tag, "_skor"}, int'(bus.skor), 0);
    kontrol({tag, "_toplam"}, int'(bus.toplam), 0);
    kontrol({tag, "_tam_sayi"}, int'(bus.tam_sayi), 0);
    kontrol({tag, "_mesgul"}, int'(bus.mesgul), 0);
    kontrol({tag, "_bitti"}, int'(bus.bitti), 0);
    kontrol({tag, "_gecti"}, int'(bus.gecti), 0);
  endtask

  initial begin
    logic [5:0] k;
    rst = 1'b1;
    bus.basla = 1'b0;
    bus.iptal = 1'b0;
    bus.giris_gecerli = 1'b0;
    bus.kodon1 = '0;
    bus.kodon2 = '0;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Identical pairs back to back: all perfect matches.
    start_job();
    kontrol("t1_mesgul", int'(bus.mesgul), 1);
    for (int i = 0; i < N_KODON; i++) begin
      k = 6'(i * 9 + 3);
      send(k, k, 0);
    end
    finish_job("t1", 24, 8, 1);

    // No matching positions, idle gaps between pairs.
    start_job();
    for (int i = 0; i < N_KODON; i++)
      send(6'b000000, 6'b010101, (i == N_KODON-1) ? 0 : 2);
    finish_job("t2", 0, 0, 0);

    // Alternating 1/2 scores land exactly on the threshold; stray basla mid-job.
    start_job();
    for (int i = 0; i < N_KODON; i++) begin
      send(6'b000000, (i % 2 == 0) ? 6'b000101 : 6'b000001, 0);
      if (i == 3) begin
        bus.basla = 1'b1;
        @(posedge clk); #1 bus.basla = 1'b0;
        kontrol("t3_mesgul_mid", int'(bus.mesgul), 1);
      end
    end
    finish_job("t3", 12, 0, 1);

    // Abort after three transfers.
    start_job();
    for (int i = 0; i < 3; i++) send(6'b111001, 6'b111001, 0);
    @(posedge clk); #1 bus.iptal = 1'b1;
    @(posedge clk); #1 bus.iptal = 1'b0;
    @(negedge clk);
    kontrol("t4_mesgul", int'(bus.mesgul), 0);
    kontrol("t4_toplam_part", int'(bus.toplam), 9);
    kontrol("t4_tam_part", int'(bus.tam_sayi), 3);
    kontrol("t4_gecti", int'(bus.gecti), 0);
    kontrol("t4_bitti", int'(bus.bitti), 0);
    repeat (3) begin
      @(negedge clk);
      kontrol("t4_no_bitti", int'(bus.bitti), 0);
    end
    start_job();
    @(negedge clk);
    kontrol("t4_restart_toplam", int'(bus.toplam), 0);
    kontrol("t4_restart_tam", int'(bus.tam_sayi), 0);
    kontrol("t4_restart_mesgul", int'(bus.mesgul), 1);

    // Asynchronous reset in the middle of that job.
    @(posedge clk); #1;
    send(6'b101010, 6'b101010, 0);
    send(6'b101010, 6'b101010, 0);
    #2 rst = 1'b1;
    #1 check_zero("t5_async");
    @(posedge clk); #1 rst = 1'b0;

    // Valid pairs while idle must change nothing.
    bus.kodon1 = 6'b110011;
    bus.kodon2 = 6'b110011;
    bus.giris_gecerli = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.giris_gecerli = 1'b0;
    @(negedge clk);
    check_zero("t5_idle");

    // Block still works after the reset.
    start_job();
    for (int i = 0; i < N_KODON; i++) send(6'b011011, 6'b011011, 0);
    finish_job("t6", 24, 8, 1);

    kontrol("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
